// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary weight unpacker: 2-bit code values,
// signed weight values, FSM state encoding and ui_param field positions.
package tt_ternary_pkg;

  // Packed 2-bit weight codes as they arrive on the input bus
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;
  localparam logic [1:0] CODE_ILL  = 2'b10;

  // Decoded signed 2-bit weights
  localparam logic signed [1:0] W_ZERO = 2'sb00;
  localparam logic signed [1:0] W_POS  = 2'sb01;
  localparam logic signed [1:0] W_NEG  = 2'sb11;

  // Loader states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Input word and shape-parameter layout
  localparam int IN_W     = 16;
  localparam int PARAM_W  = 7;
  localparam int ROWS_MSB = 6;
  localparam int ROWS_LSB = 3;
  localparam int COLS_MSB = 2;
  localparam int COLS_LSB = 0;

  // Map one code to its weight; the illegal code reads as zero
  function automatic logic signed [1:0] decode_code(input logic [1:0] code);
    case (code)
      CODE_POS: return W_POS;
      CODE_NEG: return W_NEG;
      default:  return W_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/tt_ternary_decode.sv
// Single-column ternary decoder: one 2-bit code to one signed 2-bit weight.
// The illegal-code flag port exists only when TERNARY_ERR_EN is defined.
module tt_ternary_decode
  import tt_ternary_pkg::*;
(
  input  logic [1:0]        code,
  output logic signed [1:0] weight
`ifdef TERNARY_ERR_EN
  ,
  output logic              illegal
`endif
);

  // Pure table lookup, no state
  assign weight = decode_code(code);

`ifdef TERNARY_ERR_EN
  // Flag the reserved code so the top can raise its sticky error
  assign illegal = (code == CODE_ILL);
`endif

endmodule

// File: rtl/tt_um_weight_unpack.sv
// Ternary weight unpacker: loads one packed 16-bit row per accepted word into
// a MAX_IN_LEN x MAX_OUT_LEN array of signed 2-bit weights.
// Optional feature: TERNARY_ERR_EN enables the sticky illegal-code flag uo_err;
// without it uo_err is tied low.
module tt_um_weight_unpack
  import tt_ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ena,
  input  logic [IN_W-1:0]                      ui_input,
  input  logic [PARAM_W-1:0]                   ui_param,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  uo_weights,
  output logic                                 uo_done,
  output logic                                 uo_busy,
  output logic                                 uo_err
);

  localparam int ROW_W      = 2 * MAX_OUT_LEN;
  localparam int CNT_W      = (MAX_IN_LEN > 1) ? $clog2(MAX_IN_LEN) : 1;
  localparam int IN_COLS    = IN_W / 2;
  localparam int ROWS_W     = ROWS_MSB - ROWS_LSB + 1;
  localparam int COLS_W     = COLS_MSB - COLS_LSB + 1;
  localparam int ROWS_MAX_I = (1 << ROWS_W) - 1;
  localparam int ROWS_CAP_I = (MAX_IN_LEN - 1 > ROWS_MAX_I) ? ROWS_MAX_I : MAX_IN_LEN - 1;
  localparam logic [ROWS_W-1:0] ROWS_CAP = ROWS_W'(ROWS_CAP_I);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     row_cnt_reg, row_cnt_next;
  logic [PARAM_W-1:0]   param_reg, param_next;
  logic                 done_reg, done_next;

  logic                 load_start;
  logic                 fill_write;
  logic [ROWS_W-1:0]    rows_in;
  logic [CNT_W-1:0]     row_last;
  logic [COLS_W-1:0]    cols_sel;
  logic [ROW_W-1:0]     dec_row;
  logic [MAX_OUT_LEN-1:0] col_active;
`ifdef TERNARY_ERR_EN
  logic [MAX_OUT_LEN-1:0] col_illegal;
  logic                 err_reg;
`endif

  // A rows field larger than the array is clamped so the counter never wraps
  assign rows_in  = (ui_param[ROWS_MSB:ROWS_LSB] > ROWS_CAP) ? ROWS_CAP
                                                             : ui_param[ROWS_MSB:ROWS_LSB];
  assign row_last = CNT_W'(param_reg[ROWS_MSB:ROWS_LSB]);

  // The first word of a load uses the live shape, later words the latched one
  assign cols_sel = (state_reg == ST_IDLE) ? ui_param[COLS_MSB:COLS_LSB]
                                           : param_reg[COLS_MSB:COLS_LSB];

  // One decoder per column; inactive or beyond-bus columns decode to zero
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT_LEN; gi++) begin : g_col
      logic [1:0]        code;
      logic signed [1:0] weight;
`ifdef TERNARY_ERR_EN
      logic              illegal;
`endif

      if (gi < IN_COLS) begin : g_live
        localparam logic [COLS_W-1:0] COL_IDX = COLS_W'(gi);
        assign code           = ui_input[2*gi +: 2];
        assign col_active[gi] = (COL_IDX <= cols_sel);
      end else begin : g_pad
        assign code           = CODE_ZERO;
        assign col_active[gi] = 1'b0;
      end

      tt_ternary_decode u_dec (
        .code    (code),
        .weight  (weight)
`ifdef TERNARY_ERR_EN
        ,
        .illegal (illegal)
`endif
      );

      assign dec_row[2*gi +: 2] = col_active[gi] ? weight : W_ZERO;
`ifdef TERNARY_ERR_EN
      assign col_illegal[gi] = col_active[gi] & illegal;
`endif
    end
  endgenerate

  // Next-state logic: decides when a word is accepted and where it goes
  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    param_next   = param_reg;
    done_next    = 1'b0;
    load_start   = 1'b0;
    fill_write   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ena) begin
          load_start   = 1'b1;
          param_next   = {rows_in, ui_param[COLS_MSB:COLS_LSB]};
          row_cnt_next = CNT_W'(1);
          if (rows_in == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (ena) begin
          fill_write = 1'b1;
          if (row_cnt_reg == row_last) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            row_cnt_next = row_cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!ena) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Control registers: state, row counter, latched shape and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      row_cnt_reg <= '0;
      param_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      param_reg   <= param_next;
      done_reg    <= done_next;
    end
  end

  // Weight rows: a load start writes row 0 and clears the rest in one edge
  generate
    for (gi = 0; gi < MAX_IN_LEN; gi++) begin : g_row
      localparam logic [CNT_W-1:0] ROW_IDX = CNT_W'(gi);
      logic [ROW_W-1:0] row_reg;

      // Row storage; only accepted words or reset change it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (load_start) begin
          row_reg <= (gi == 0) ? dec_row : '0;
        end else if (fill_write && (row_cnt_reg == ROW_IDX)) begin
          row_reg <= dec_row;
        end
      end

      assign uo_weights[gi*ROW_W +: ROW_W] = row_reg;
    end
  endgenerate

`ifdef TERNARY_ERR_EN
  // Sticky error: restarted from the first word of each load, then accumulates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (load_start) begin
      err_reg <= |col_illegal;
    end else if (fill_write && (|col_illegal)) begin
      err_reg <= 1'b1;
    end
  end

  assign uo_err = err_reg;
`else
  assign uo_err = 1'b0;
`endif

  assign uo_done = done_reg;
  assign uo_busy = (state_reg == ST_FILL);

endmodule

// File: tb/tb_tt_um_weight_unpack.sv
// Directed bench for tt_um_weight_unpack. Expected weight images are pushed to
// a scoreboard queue when a load is driven and popped on the uo_done pulse.
// Honours TERNARY_ERR_EN for the expected uo_err value.
module tb_tt_um_weight_unpack;

  localparam int IN_LEN  = 16;
  localparam int OUT_LEN = 8;
  localparam int W       = 2 * IN_LEN * OUT_LEN;
`ifdef TERNARY_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b0;
  logic [15:0]  ui_input = '0;
  logic [6:0]   ui_param = '0;
  logic [W-1:0] uo_weights;
  logic         uo_done;
  logic         uo_busy;
  logic         uo_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] sb_q [$];
  logic [15:0]  words [16];

  always #5 clk = ~clk;

  tt_um_weight_unpack #(
    .MAX_IN_LEN  (IN_LEN),
    .MAX_OUT_LEN (OUT_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ui_input   (ui_input),
    .ui_param   (ui_param),
    .uo_weights (uo_weights),
    .uo_done    (uo_done),
    .uo_busy    (uo_busy),
    .uo_err     (uo_err)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference image: rows 0..rows-1, cols 0..cols-1 decoded, everything else 0
  function automatic logic [W-1:0] model(input logic [6:0] p, input logic [15:0] wv [16]);
    logic [W-1:0] img;
    logic [1:0]   code;
    logic [1:0]   v;
    img = '0;
    for (int r = 0; r <= int'(p[6:3]); r++) begin
      for (int c = 0; c <= int'(p[2:0]); c++) begin
        code = wv[r][2*c +: 2];
        case (code)
          2'b01:   v = 2'b01;
          2'b11:   v = 2'b11;
          default: v = 2'b00;
        endcase
        img[(r*OUT_LEN + c)*2 +: 2] = v;
      end
    end
    return img;
  endfunction

  // Drive one complete load from IDLE, optionally stalling, then sit in DONE
  // with ena high and junk on the inputs before dropping ena.
  task automatic run_load(input string tag, input logic [6:0] p,
                          input int stall_after, input int stall_len);
    int n;
    int done_seen;
    int busy_low;
    int busy_in_done;
    int stall_changed;
    int lat;
    logic [W-1:0] exp_img;
    logic [W-1:0] snap;
    n = int'(p[6:3]) + 1;
    sb_q.push_back(model(p, words));
    done_seen = 0; busy_low = 0; busy_in_done = 0; stall_changed = 0; lat = 0;
    exp_img = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_done) done_seen++;
      if (i > 0 && !uo_busy) busy_low++;
      if (i == stall_after && stall_len > 0) begin
        ena  = 1'b0;
        snap = uo_weights;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          if (uo_done) done_seen++;
          if (!uo_busy) busy_low++;
          if (uo_weights !== snap) stall_changed++;
        end
      end
      ena      = 1'b1;
      ui_input = words[i];
      ui_param = (i == 0) ? p : 7'($urandom);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (uo_done) begin
        done_seen++;
        if (lat == 0) begin
          lat     = k;
          exp_img = sb_q.pop_front();
          check({tag, "_weights"}, uo_weights, exp_img);
        end
      end
      if (uo_busy) busy_in_done++;
      ui_input = 16'($urandom);
      ui_param = 7'($urandom);
    end
    if (lat == 0) begin
      exp_img = sb_q.pop_front();
      check({tag, "_weights"}, uo_weights, exp_img);
    end
    check_int({tag, "_done_lat"}, lat, 1);
    check_int({tag, "_done_cnt"}, done_seen, 1);
    check_int({tag, "_busy_fill"}, busy_low, 0);
    check_int({tag, "_busy_done"}, busy_in_done, 0);
    if (stall_len > 0) check_int({tag, "_stall_hold"}, stall_changed, 0);
    check({tag, "_done_hold"}, uo_weights, exp_img);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle_hold"}, uo_weights, exp_img);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] img;

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_weights", uo_weights, '0);
    check_int("rst_done", int'(uo_done), 0);
    check_int("rst_busy", int'(uo_busy), 0);
    check_int("rst_err", int'(uo_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_weights", uo_weights, '0);
    $display("[TB] reset checked");

    // Full 16x8 load of +1
    for (int i = 0; i < 16; i++) words[i] = 16'h5555;
    run_load("full", 7'h7F, -1, 0);
    img = {16{16'h5555}};
    check("full_const", uo_weights, img);
    $display("[TB] full load done");

    // Partial shape: 3 rows, 4 columns of -1
    for (int i = 0; i < 16; i++) words[i] = 16'hFFFF;
    run_load("partial", {4'd2, 3'd3}, -1, 0);
    img = '0;
    img[47:0] = {16'h00FF, 16'h00FF, 16'h00FF};
    check("partial_const", uo_weights, img);
    $display("[TB] partial load done");

    // Stall after word 4 for 5 cycles with distinct rows
    for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
    run_load("stall", 7'h7F, 4, 5);
    $display("[TB] stalled load done");

    // Illegal code in row 0 col 0
    for (int i = 0; i < 16; i++) words[i] = 16'h0000;
    words[0] = 16'h0002;
    words[1] = 16'h0001;
    run_load("illegal", {4'd1, 3'd7}, -1, 0);
    check("illegal_w00", W'(uo_weights[1:0]), '0);
    check_int("illegal_err", int'(uo_err), ERR_EXP);
    $display("[TB] illegal row0 load done");

    // Illegal code only in an inactive column: new load clears the flag
    words[0] = 16'h0008;
    run_load("inactive_ill", {4'd0, 3'd0}, -1, 0);
    check_int("inactive_ill_err", int'(uo_err), 0);
    $display("[TB] inactive-column load done");

    // Illegal code arriving during FILL
    words[0] = 16'h0001;
    words[1] = 16'h0020;
    run_load("fill_ill", {4'd1, 3'd7}, -1, 0);
    check_int("fill_ill_err", int'(uo_err), ERR_EXP);
    $display("[TB] illegal row1 load done");

    // Single row
    words[0] = 16'h4411;
    run_load("single", {4'd0, 3'd7}, -1, 0);
    img = '0;
    img[15:0] = 16'h4411;
    check("single_const", uo_weights, img);
    $display("[TB] single row load done");

    // Reset in the middle of a load
    for (int i = 0; i < 16; i++) words[i] = 16'h5555;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ena      = 1'b1;
      ui_input = 16'h5555;
      ui_param = (i == 0) ? 7'h7F : 7'($urandom);
    end
    @(negedge clk);
    ena = 1'b0;
    check("mid_partial", uo_weights, model({4'd6, 3'd7}, words));
    check_int("mid_busy", int'(uo_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_weights", uo_weights, '0);
    check_int("mid_rst_busy", int'(uo_busy), 0);
    check_int("mid_rst_done", int'(uo_done), 0);
    check_int("mid_rst_err", int'(uo_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] mid-load reset done");
    for (int i = 0; i < 16; i++) words[i] = 16'hFFFF;
    run_load("after_rst", {4'd1, 3'd7}, -1, 0);
    img = '0;
    img[31:0] = {16'hFFFF, 16'hFFFF};
    check("after_rst_const", uo_weights, img);
    $display("[TB] post-reset load done");

    check_int("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
